llr_former: RTL and testbench

- Front-end stage sitting directly upstream of the Fano decoder.
- Takes signed I/Q soft samples, applies one of several phase-ambiguity hypotheses (k×90° rotation), and slices each sample to the 2-bit hard symbol {d,p} the decoder consumes on i_vld/i_data.
- Steps to the next hypothesis on the decoder's phase-shift request.
- Reports a wrap of the hypothesis list back to the decoder.

---
 rtl/llr_former_pkg.sv | 38 +++
 rtl/llr_former_iq_rotator.sv | 43 ++++
 rtl/llr_former.sv | 110 +++++++++++
 tb/tb_llr_former.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/llr_former_pkg.sv
// ============================================================================
// llr_former_pkg : shared types and the sign-only rotate/slice helper
// Rev 1.0
// ============================================================================
`default_nettype none

package llr_former_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [1:0] hard_sym_t;

  localparam int NUM_PHASES_BASE = 4;
  localparam int NUM_PHASES_SWAP = 8;

  // Works on sign/zero flags only, so -x never needs an adder and the most
  // negative input cannot overflow: sign(-x) is simply "x > 0".
  function automatic hard_sym_t rot_sign(input phase_t p, input logic s_i,
                                         input logic s_q, input logic z_i,
                                         input logic z_q);
    logic a_s, a_z, b_s, b_z;
    hard_sym_t sym;
    if (p[2]) begin
      a_s = s_q; a_z = z_q; b_s = s_i; b_z = z_i;
    end else begin
      a_s = s_i; a_z = z_i; b_s = s_q; b_z = z_q;
    end
    case (p[1:0])
      2'd0:    sym = {a_s, b_s};
      2'd1:    sym = {!b_s && !b_z, a_s};
      2'd2:    sym = {!a_s && !a_z, !b_s && !b_z};
      default: sym = {b_s, !a_s && !a_z};
    endcase
    return sym;
  endfunction

endpackage

`default_nettype wire

// File: rtl/llr_former_iq_rotator.sv
// ============================================================================
// iq_rotator : stage 1, rotates an I/Q sample by the phase hypothesis and
// registers the sliced sign bits with their valid. Rev 1.0
// ============================================================================
`default_nettype none

module iq_rotator
  import llr_former_pkg::*;
#(
  parameter int IQ_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_vld,
  input  logic [IQ_WIDTH-1:0] in_i,
  input  logic [IQ_WIDTH-1:0] in_q,
  input  phase_t              phase,
  output logic                s1_vld,
  output hard_sym_t           s1_sym
);

  logic sign_i, sign_q, zero_i, zero_q;

  assign sign_i = in_i[IQ_WIDTH-1];
  assign sign_q = in_q[IQ_WIDTH-1];
  assign zero_i = (in_i == '0);
  assign zero_q = (in_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_sym <= '0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_sym <= rot_sign(phase, sign_i, sign_q, zero_i, zero_q);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/llr_former.sv
// ============================================================================
// llr_former : phase-hypothesis rotator and hard slicer ahead of the Fano
// decoder. LLR_FORMER_IQ_SWAP_EN adds four I/Q-swapped hypotheses. Rev 1.0
// ============================================================================
`default_nettype none

module llr_former
  import llr_former_pkg::*;
#(
  parameter int IQ_WIDTH   = 8,
  parameter int SETTLE_LEN = 4,
  parameter int DEBUG      = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_vld,
  input  logic [IQ_WIDTH-1:0] i_data_i,
  input  logic [IQ_WIDTH-1:0] i_data_q,
  input  logic                i_shift_phs,
  input  logic                i_llr_reset,
  input  logic                i_lock,
  output logic                o_vld,
  output logic [1:0]          o_data,
  output logic                o_last_phase_stb,
  output logic [2:0]          o_phase
);

`ifdef LLR_FORMER_IQ_SWAP_EN
  localparam int NUM_PHASES = NUM_PHASES_SWAP;
  localparam int PW         = 3;
`else
  localparam int NUM_PHASES = NUM_PHASES_BASE;
  localparam int PW         = 2;
`endif
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);
  localparam int            CW         = (SETTLE_LEN > 0) ? $clog2(SETTLE_LEN + 1) : 1;

  logic [PW-1:0] phase_q, phase_nxt;
  logic [CW-1:0] settle;
  logic          shift_acc, flush, v2;
  logic          s1_vld;
  hard_sym_t     s1_sym;

  // llr reset has priority over a coincident shift request.
  assign shift_acc = i_shift_phs && !i_lock && !i_llr_reset;
  assign flush     = shift_acc || i_llr_reset;
  assign v2        = s1_vld && !flush;

  always_comb begin
    phase_nxt = phase_q;
    if (i_llr_reset) begin
      phase_nxt = '0;
    end else if (shift_acc) begin
      phase_nxt = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
    end
  end

  // The sample arriving with the request is rotated by the new hypothesis.
  iq_rotator #(
    .IQ_WIDTH(IQ_WIDTH)
  ) u_rot (
    .clk    (clk),
    .reset_n(reset_n),
    .in_vld (i_vld),
    .in_i   (i_data_i),
    .in_q   (i_data_q),
    .phase  (phase_t'(phase_nxt)),
    .s1_vld (s1_vld),
    .s1_sym (s1_sym)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q          <= '0;
      o_last_phase_stb <= 1'b0;
      o_vld            <= 1'b0;
      o_data           <= '0;
      settle           <= CW'(SETTLE_LEN);
    end else begin
      phase_q          <= phase_nxt;
      o_last_phase_stb <= shift_acc && (phase_q == LAST_PHASE);
      o_vld            <= v2 && (settle == '0);
      if (s1_vld) begin
        o_data <= s1_sym;
      end
      if (flush) begin
        settle <= CW'(SETTLE_LEN);
      end else if (v2 && (settle != '0)) begin
        settle <= settle - 1'b1;
      end
    end
  end

  assign o_phase = phase_t'(phase_q);

`ifndef SYNTHESIS
  generate
    if (DEBUG != 0) begin : g_debug
      always_ff @(posedge clk) begin
        if (reset_n && (phase_nxt != phase_q)) begin
          $display("[llr_former] phase %0d -> %0d", phase_q, phase_nxt);
        end
      end
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_llr_former.sv
// ============================================================================
// tb_llr_former : directed stimulus with a queued scoreboard on the symbol
// stream plus direct checks of phase, strobe and settle blanking. Rev 1.0
// ============================================================================
`default_nettype none

module tb_llr_former;

`ifdef LLR_FORMER_IQ_SWAP_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              vld = 1'b0, shift = 1'b0, llr = 1'b0, lock = 1'b0;
  logic signed [7:0] di = '0, dq = '0;
  logic              ovld, ostb;
  logic [1:0]        odata;
  logic [2:0]        ophase;

  logic              vld4 = 1'b0, shift4 = 1'b0;
  logic              ovld4, ostb4;
  logic [1:0]        odata4;
  logic [2:0]        ophase4;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] d;
    int         due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  llr_former #(.IQ_WIDTH(8), .SETTLE_LEN(0), .DEBUG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_vld(vld), .i_data_i(di), .i_data_q(dq),
    .i_shift_phs(shift), .i_llr_reset(llr), .i_lock(lock),
    .o_vld(ovld), .o_data(odata), .o_last_phase_stb(ostb), .o_phase(ophase)
  );

  llr_former #(.IQ_WIDTH(8), .SETTLE_LEN(4), .DEBUG(0)) dut4 (
    .clk(clk), .reset_n(reset_n), .i_vld(vld4), .i_data_i(8'sd4), .i_data_q(8'sd4),
    .i_shift_phs(shift4), .i_llr_reset(1'b0), .i_lock(1'b0),
    .o_vld(ovld4), .o_data(odata4), .o_last_phase_stb(ostb4), .o_phase(ophase4)
  );

  // Monitor: every emitted symbol must match the head of the queue, on time.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && ovld) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sym_unexpected: got %b at cyc %0d, nothing expected", odata, cyc);
      end else begin
        e = sb.pop_front();
        if (odata !== e.d || cyc != e.due) begin
          fails++;
          $display("FAIL sym: got %b at cyc %0d, want %b at cyc %0d", odata, cyc, e.d, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One cycle of dut0 stimulus; a kept sample is due two clocks later.
  task automatic drive(input logic v, input int i, input int q, input logic sh,
                       input logic lr, input logic lk, input logic keep,
                       input logic [1:0] expd);
    vld = v; di = 8'(i); dq = 8'(q); shift = sh; llr = lr; lock = lk;
    if (v && keep) sb.push_back('{expd, cyc + 2});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic tick4(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [1:0] exp_tab [4];

  initial begin
    exp_tab = '{2'b00, 2'b10, 2'b11, 2'b01};
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    check("reset_vld",   int'(ovld),   0);
    check("reset_data",  int'(odata),  0);
    check("reset_phase", int'(ophase), 0);
    check("reset_stb",   int'(ostb),   0);

    // Phase 0 slicing, including a zero component.
    drive(1'b1,  5, -3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    drive(1'b1, -1,  0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    drive(1'b1,  0,  7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    idle(3);

    // Step through hypotheses with a symbol in flight at each request.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      drive(1'b1, 4, 4, 1'b1, 1'b0, 1'b0, 1'b1, exp_tab[k % 4]);
      check("shift_phase", int'(ophase), k % NPH);
      check("shift_stb",   int'(ostb),   (k % NPH == 0) ? 1 : 0);
      drive(1'b1, 4, 4, 1'b0, 1'b0, 1'b0, 1'b1, exp_tab[k % 4]);
      check("stb_one_cycle", int'(ostb), 0);
      if (k == 1) drive(1'b1, -128, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
      if (k == 2) begin
        drive(1'b1, -128, -128, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        drive(1'b1,    0,    0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      end
      idle(2);
    end
`ifdef LLR_FORMER_IQ_SWAP_EN
    drive(1'b1, -2, 6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    idle(2);
`endif

    // llr reset alone: phase to 0, no strobe.
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check("llr_phase", int'(ophase), 0);
    check("llr_stb",   int'(ostb),   0);
    idle(2);

    // Locked: shift ignored, stream uninterrupted.
    drive(1'b1, 5, -3, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    drive(1'b1, 5, -3, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
    check("lock_phase", int'(ophase), 0);
    check("lock_stb",   int'(ostb),   0);
    drive(1'b1, 5, -3, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    idle(3);

    // At phase 3, coincident shift and llr reset: reset wins.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      idle(1);
    end
    check("pre_coinc_phase", int'(ophase), 3);
    drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    check("coinc_phase", int'(ophase), 0);
    check("coinc_stb",   int'(ostb),   0);
    idle(1);
    check("coinc_stb_after", int'(ostb), 0);
    drive(1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    idle(3);

    // Settle blanking on the SETTLE_LEN=4 instance.
    vld4 = 1'b1;
    tick4(12);
    check("settle_steady_vld", int'(ovld4), 1);
    shift4 = 1'b1;
    tick4(1);
    shift4 = 1'b0;
    check("settle_flush_vld", int'(ovld4), 0);
    for (int j = 1; j <= 9; j++) begin
      tick4(1);
      check("settle_vld", int'(ovld4), (j >= 5) ? 1 : 0);
    end
    check("settle_data",  int'(odata4),  2);
    check("settle_phase", int'(ophase4), 1);

    // Mid-stream reset: immediate clear, then full settle before output.
    #2 reset_n = 1'b0;
    #1;
    check("midreset_vld",   int'(ovld4),   0);
    check("midreset_phase", int'(ophase4), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick4(1);
      check("post_reset_vld", int'(ovld4), (j >= 6) ? 1 : 0);
    end
    vld4 = 1'b0;
    tick4(3);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
